seq_chunk_adder: RTL
====================

Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder/subtractor for the adder library. It processes operands CHUNK bits per clock, rippling the carry between chunks through an internal register. This trades latency for a small per-cycle carry chain. Valid/ready handshakes on input and output let it sit between sequential producers and consumers in the adder datapath.

Parameters:
WIDTH, 16, operand and result width in bits; must be >= 1.
CHUNK, 4, bits added per cycle; WIDTH % CHUNK must be 0, otherwise elaboration fails ($error / $fatal). Derived N = WIDTH/CHUNK is the number of BUSY cycles.

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: a+b+cin; 1: a-b-cin
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry-out; in sub mode 1 = no borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: synchronous active-high, checked every rising edge, overrides everything including mid-operation.
  - State after reset: IDLE; in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Chunk counter and carry register cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - Latch a.
    - Latch b_eff = sub ? ~b : b.
    - Latch carry = sub ? ~cin : cin.
    - Set counter = 0 and go to BUSY.
  - Handshake signals sampled only at the edge; other inputs are ignored outside IDLE.
- BUSY:
  - in_ready=0.
  - Each cycle k (0..N-1): {c, s} = a[k*CHUNK +: CHUNK] + b_eff[k*CHUNK +: CHUNK] + carry. Write s into sum[k*CHUNK +: CHUNK], set carry = c, increment counter.
  - On k = N-1:
    - cout = c.
    - ovf = (carry into bit WIDTH-1) XOR c.
    - Go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf held stable.
  - On out_ready go to IDLE, and out_valid drops next cycle.
  - Without out_ready, hold indefinitely (backpressure).
- Latency and throughput:
  - Operands accepted at edge t; out_valid is first high after edge t+N.
  - Minimum initiation interval is N+2 cycles: one bubble in IDLE, no accept during DONE.
- sum is intermediate (partially updated) during BUSY and must only be sampled when out_valid=1.
- CHUNK == WIDTH gives N=1 (single BUSY cycle).
- WIDTH == 1: ovf = cin_into_msb ^ cout per the same rule.
- Counter width is $clog2(N)+1 bits so it cannot wrap before N.
- Reset asserted in BUSY or DONE aborts the operation with no output produced.
- in_valid held high during BUSY/DONE is not accepted. It is taken on the first IDLE cycle.

Optional Feature:
Macro: SEQ_CHUNK_ADDER_FLAGS_EN.
- Defined: adds outputs zero (1 = sum is all-zero) and neg (= sum[WIDTH-1]).
  - Both registered, valid with out_valid, cleared to 0 on reset.
  - zero is accumulated per chunk: starts at 1 on accept and is ANDed with (s==0) each BUSY cycle.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan (WIDTH=16, CHUNK=4, N=4):
1. Reset: assert rst 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, sum=0x0000, cout=0, ovf=0; no operand accepted.
2. Add: a=0x1234, b=0x4321, cin=0, sub=0 -> out_valid exactly 4 cycles after accept; sum=0x5555, cout=0, ovf=0.
3. Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (zero=1 with FLAGS_EN).
4. Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1 (neg=1 with FLAGS_EN).
5. Subtract: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0; and a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
6. Backpressure and abort:
   - Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, pending in_valid not accepted until after the out handshake.
   - Separately, assert rst in the 2nd BUSY cycle -> IDLE next cycle, out_valid never asserts.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
//   Multi-cycle adder/subtractor. The operands are processed CHUNK bits per
//   clock, least-significant chunk first. The carry between chunks is held in a
//   register, so each cycle needs only a CHUNK-bit carry chain. The block takes
//   N = WIDTH/CHUNK BUSY cycles per operation.
//
// Parameters
//   WIDTH      operand/result width (>= 1)
//   CHUNK      bits added per cycle (WIDTH % CHUNK must be 0)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands presented            in_ready   accepting operands (IDLE)
//   a, b       operands                      cin        carry-in / borrow-in
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid (DONE)           out_ready  consumer takes result
//   sum        result (only meaningful while out_valid)
//   cout       carry-out; in sub mode 1 = no borrow
//   ovf        two's-complement signed overflow
//
// Optional feature (macro SEQ_CHUNK_ADDER_FLAGS_EN)
//   zero       1 when sum is all-zero        neg        sum[WIDTH-1]
// -----------------------------------------------------------------------------
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int N  = WIDTH / CHUNK;
  // One extra bit so the counter can never wrap before reaching N-1.
  localparam int CW = $clog2(N) + 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_chunk_adder: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q,     a_d;
  logic [WIDTH-1:0]  b_q,     b_d;     // already inverted in sub mode
  logic [WIDTH-1:0]  sum_q,   sum_d;
  logic              cout_q,  cout_d;
  logic              ovf_q,   ovf_d;
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
  logic              zero_q,  zero_d;
`endif

  // Chunk datapath
  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK-1:0]  s_chunk;
  logic              c_chunk;
  logic              c_msb;    // carry into the top bit of the current chunk
  logic              last;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    a_chunk = '0;
    b_chunk = '0;
    // Constant-index selection keeps the mux width-clean for any N.
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK + 1)'(carry_q);
    // The sum bit is a^b^carry_in, so the carry into the MSB falls out of it.
    c_msb = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];
    last  = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
    zero_d  = zero_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          // Subtraction as a + ~b + 1; borrow-in flips the injected carry.
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
          zero_d  = 1'b1;
`endif
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CW'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = s_chunk;
          end
        end
        carry_d = c_chunk;
        cnt_d   = cnt_q + CW'(1);
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
        zero_d  = zero_q & (s_chunk == '0);
`endif
        if (last) begin
          cout_d  = c_chunk;
          ovf_d   = c_msb ^ c_chunk;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand and result registers are reset too: sum/cout/ovf have
      // defined reset values, and clearing the operands costs nothing here.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
`ifdef SEQ_CHUNK_ADDER_FLAGS_EN
  assign zero      = zero_q;
  assign neg       = sum_q[WIDTH-1];
`endif

endmodule
